// File: rtl/memory_game_pkg.sv
// Shared definitions for the memory-game blocks.
//   SYMBOL_W : width of a pattern / guess symbol
//   SCORE_W  : width of a round score (a round holds at most 7 guesses)
//   IDX_W    : width of a guess index within a round
//   state_t  : round_scorer FSM encoding, also exported on its debug port
package memory_game_pkg;

    localparam int SYMBOL_W = 3;
    localparam int SCORE_W  = 3;
    localparam int IDX_W    = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/guess_timer.sv
// guess_timer: counts consecutive cycles in which a guess is awaited but not
// given, and flags the cycle on which that count reaches TIMEOUT_CYCLES.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   run     : high while waiting for a guess; low clears the count
//   expired : high during the TIMEOUT_CYCLES-th consecutive run cycle
// Only instantiated by round_scorer when GUESS_TIMEOUT_EN is defined.
module guess_timer #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // count holds the number of run cycles already elapsed, so the cycle
    // seeing LAST_CNT is the TIMEOUT_CYCLES-th one.
    assign expired = run && (count == LAST_CNT);

    always_ff @(posedge clk) begin
        if (rst || !run || expired) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/round_scorer.sv
// round_scorer: runs one round of ROUND_LEN guesses, counts guesses that
// match the pattern symbol, and publishes the round score.
// Ports:
//   clk, rst    : clock and synchronous active-high reset
//   roundStart  : pulse starting (IDLE) or restarting (PLAY) a round
//   guess       : player symbol, qualified by guessValid
//   expected    : pattern symbol at guessIdx, valid in the same cycle
//   guessIdx    : index of the guess currently awaited
//   newScore    : score of the last completed round, held between pulses
//   scoreValid  : one-cycle pulse when newScore is updated
//   busy        : high while a round is in PLAY
//   dbgState    : current FSM state
// Handshake: a guess is taken in any PLAY cycle where guessValid is high and
// roundStart is low; there is no back-pressure, so guessValid is a one-cycle
// qualifier and the caller must present expected for the current guessIdx.
// Optional feature: define GUESS_TIMEOUT_EN to count a missing guess as a
// wrong one after TIMEOUT_CYCLES idle PLAY cycles.
module round_scorer
    import memory_game_pkg::*;
#(
    parameter int ROUND_LEN      = 7,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                roundStart,
    input  logic [SYMBOL_W-1:0] guess,
    input  logic                guessValid,
    input  logic [SYMBOL_W-1:0] expected,
    output logic [IDX_W-1:0]    guessIdx,
    output logic [SCORE_W-1:0]  newScore,
    output logic                scoreValid,
    output logic                busy,
    output state_t              dbgState
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUND_LEN - 1);

    state_t               state;
    state_t               stateNext;
    logic [IDX_W-1:0]     idxQ;
    logic [SCORE_W-1:0]   correctQ;
    logic [SCORE_W-1:0]   scoreQ;

    logic inPlay;
    logic acceptGuess;
    logic isMatch;
    logic timeoutHit;
    logic advance;
    logic lastGuess;

    assign inPlay      = (state == ST_PLAY);
    // A restart in the same cycle swallows the guess.
    assign acceptGuess = inPlay && guessValid && !roundStart;
    assign isMatch     = acceptGuess && (guess == expected);

`ifdef GUESS_TIMEOUT_EN
    logic timerRun;

    // Any guessValid stops the timer, so a guess on the expiry cycle wins.
    assign timerRun = inPlay && !roundStart && !guessValid;

    guess_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uGuessTimer (
        .clk    (clk),
        .rst    (rst),
        .run    (timerRun),
        .expired(timeoutHit)
    );
`else
    // No timer in this build; the parameter is kept so both builds share one
    // interface, and this expression is constant 0.
    assign timeoutHit = (TIMEOUT_CYCLES < 0);
`endif

    assign advance   = acceptGuess || timeoutHit;
    assign lastGuess = (idxQ == LAST_IDX);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        unique case (state)
            ST_IDLE: if (roundStart)           stateNext = ST_PLAY;
            ST_PLAY: if (advance && lastGuess) stateNext = ST_DONE;
            ST_DONE:                           stateNext = ST_IDLE;
            default:                           stateNext = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy       = (state == ST_PLAY);
        scoreValid = (state == ST_DONE);
        guessIdx   = idxQ;
        newScore   = scoreQ;
        dbgState   = state;
    end

    // Round datapath: index, running correct count and published score.
    always_ff @(posedge clk) begin
        if (rst) begin
            idxQ     <= '0;
            correctQ <= '0;
            scoreQ   <= '0;
        end else if (roundStart && (state != ST_DONE)) begin
            idxQ     <= '0;
            correctQ <= '0;
        end else if (advance) begin
            correctQ <= correctQ + SCORE_W'(isMatch);
            if (lastGuess) begin
                // Final guess: index holds, score includes this guess.
                scoreQ <= correctQ + SCORE_W'(isMatch);
            end else begin
                idxQ <= idxQ + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_round_scorer.sv
module tb_round_scorer;
    import memory_game_pkg::*;

    localparam int RL = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT (ROUND_LEN=7) ----------------
    logic       roundStart = 1'b0;
    logic       guessValid = 1'b0;
    logic [2:0] guess = '0;
    logic [2:0] expected = '0;
    logic [2:0] guessIdx, newScore;
    logic       scoreValid, busy;
    state_t     dbgState;

    round_scorer #(.ROUND_LEN(RL), .TIMEOUT_CYCLES(10)) dut7 (
        .clk(clk), .rst(rst), .roundStart(roundStart), .guess(guess),
        .guessValid(guessValid), .expected(expected), .guessIdx(guessIdx),
        .newScore(newScore), .scoreValid(scoreValid), .busy(busy),
        .dbgState(dbgState)
    );

    // ---------------- DUT (ROUND_LEN=1) ----------------
    logic       rs1 = 1'b0;
    logic       gv1 = 1'b0;
    logic [2:0] g1 = '0;
    logic [2:0] e1 = '0;
    logic [2:0] idx1, ns1;
    logic       sv1, busy1;
    state_t     st1;

    round_scorer #(.ROUND_LEN(1), .TIMEOUT_CYCLES(10)) dut1 (
        .clk(clk), .rst(rst), .roundStart(rs1), .guess(g1),
        .guessValid(gv1), .expected(e1), .guessIdx(idx1),
        .newScore(ns1), .scoreValid(sv1), .busy(busy1), .dbgState(st1)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [2:0] exp_q[$];
    int         expCyc_q[$];
    logic [2:0] exp1_q[$];
    int         expCyc1_q[$];
    logic [2:0] last7 = '0;
    logic [2:0] last1 = '0;
    bit         monEn = 1'b0;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops an expected score whenever a DUT pulses scoreValid.
    always @(negedge clk) begin
        if (rst) begin
            last7 = '0;
            last1 = '0;
        end else if (monEn) begin
            if (scoreValid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_scoreValid7 actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    logic [2:0] es;
                    int ec;
                    es = exp_q.pop_front();
                    ec = expCyc_q.pop_front();
                    check("newScore7", newScore, es);
                    check("latency7", cyc, ec);
                    check("busy_in_done7", busy, 0);
                    last7 = es;
                end
            end else begin
                check("hold7", newScore, last7);
            end
            if (sv1) begin
                if (exp1_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_scoreValid1 actual=1 required=0 (cycle %0d)", cyc);
                end else begin
                    logic [2:0] es;
                    int ec;
                    es = exp1_q.pop_front();
                    ec = expCyc1_q.pop_front();
                    check("newScore1", ns1, es);
                    check("latency1", cyc, ec);
                    last1 = es;
                end
            end else begin
                check("hold1", ns1, last1);
            end
        end
    end

    // ---------------- reference model state (ROUND_LEN=7) ----------------
    int mIdx = 0;
    int mScore = 0;
    bit mPlay = 1'b0;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic reset_all();
        rst = 1'b1;
        roundStart = 1'b1;   // reset must win over both
        guessValid = 1'b1;
        guess = 3'd2;
        expected = 3'd2;
        tick();
        rst = 1'b0;
        roundStart = 1'b0;
        guessValid = 1'b0;
        mPlay = 1'b0;
        mIdx = 0;
        mScore = 0;
        check("rst_guessIdx", guessIdx, 0);
        check("rst_newScore", newScore, 0);
        check("rst_scoreValid", scoreValid, 0);
        check("rst_busy", busy, 0);
        check("rst_state", int'(dbgState), int'(ST_IDLE));
        check("rst_newScore1", ns1, 0);
        check("rst_busy1", busy1, 0);
    endtask

    task automatic start7(input bit withGuess);
        roundStart = 1'b1;
        guessValid = withGuess;
        guess = 3'($urandom_range(0, 7));
        expected = guess;    // would score if it were not ignored
        mIdx = 0;
        mScore = 0;
        mPlay = 1'b1;
        tick();
        roundStart = 1'b0;
        guessValid = 1'b0;
        check("start_busy", busy, 1);
        check("start_idx", guessIdx, 0);
        check("start_state", int'(dbgState), int'(ST_PLAY));
    endtask

    task automatic guess7(input logic [2:0] g, input logic [2:0] e);
        bit fin;
        fin = 1'b0;
        guess = g;
        expected = e;
        guessValid = 1'b1;
        if (mPlay) begin
            check("guessIdx", guessIdx, mIdx);
            if (g == e) mScore++;
            if (mIdx == RL - 1) begin
                exp_q.push_back(3'(mScore));
                expCyc_q.push_back(cyc + 1);
                mPlay = 1'b0;
                fin = 1'b1;
            end else begin
                mIdx++;
            end
        end
        tick();
        guessValid = 1'b0;
        if (fin) begin
            check("busy_after_final", busy, 0);
            tick();          // let the DONE cycle pass
        end else if (mPlay) begin
            check("busy_play", busy, 1);
        end else begin
            check("busy_idle", busy, 0);
        end
    endtask

    task automatic rand_guess7();
        logic [2:0] g, e;
        g = 3'($urandom_range(0, 7));
        e = ($urandom_range(0, 1) == 1) ? g : 3'($urandom_range(0, 7));
        guess7(g, e);
    endtask

    task automatic round1(input logic [2:0] g, input logic [2:0] e);
        rs1 = 1'b1;
        tick();
        rs1 = 1'b0;
        check("r1_busy", busy1, 1);
        check("r1_idx", idx1, 0);
        gv1 = 1'b1;
        g1 = g;
        e1 = e;
        exp1_q.push_back((g == e) ? 3'd1 : 3'd0);
        expCyc1_q.push_back(cyc + 1);
        tick();
        gv1 = 1'b0;
        check("r1_busy_done", busy1, 0);
        tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        idle(2);
        rst = 1'b0;
        monEn = 1'b1;
        reset_all();

        // All seven guesses match.
        start7(1'b0);
        for (int i = 0; i < RL; i++) guess7(3'(i), 3'(i));
        check("score_all_match", newScore, 7);

        // Matches only at indices 0, 2 and 5.
        start7(1'b0);
        for (int i = 0; i < RL; i++) begin
            logic [2:0] e;
            e = 3'(i + 1);
            guess7((i == 0 || i == 2 || i == 5) ? e : e ^ 3'd4, e);
        end
        check("score_025", newScore, 3);

        // Restart after four guesses (three correct), then all wrong.
        start7(1'b0);
        for (int i = 0; i < 4; i++) guess7(3'd5, (i == 3) ? 3'd1 : 3'd5);
        start7(1'b1);
        for (int i = 0; i < RL; i++) guess7(3'd6, 3'd3);
        check("score_restart", newScore, 0);

        // Reset mid-round, then guesses in IDLE are ignored.
        start7(1'b0);
        for (int i = 0; i < 5; i++) guess7(3'd4, 3'd4);
        reset_all();
        for (int i = 0; i < 3; i++) guess7(3'd1, 3'd1);
        check("idle_idx", guessIdx, 0);
        check("idle_state", int'(dbgState), int'(ST_IDLE));

`ifdef GUESS_TIMEOUT_EN
        // Ten idle PLAY cycles count as one wrong guess.
        start7(1'b0);
        idle(10);
        mIdx = 1;
        check("timeout_idx", guessIdx, 1);
        idle(9);
        guess7(3'd3, 3'd3);          // lands on the expiry cycle
        check("single_advance", guessIdx, 2);
        for (int i = 0; i < 5; i++) guess7(3'd1, 3'd1);
        check("score_timeout", newScore, 6);
`endif

        // Randomized rounds with occasional restarts and gaps.
        for (int r = 0; r < 15; r++) begin
            start7($urandom_range(0, 1) == 1);
            for (int k = 0; k < 100 && mPlay; k++) begin
                if ($urandom_range(0, 15) == 0) start7(1'b1);
                else rand_guess7();
                if (mPlay && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
            if ($urandom_range(0, 2) == 0) idle(1);
        end

        // ROUND_LEN=1: back-to-back single-guess rounds.
        round1(3'd2, 3'd2);
        check("r1_first_score", ns1, 1);
        for (int r = 0; r < 8; r++) begin
            logic [2:0] g;
            g = 3'($urandom_range(0, 7));
            round1(g, ($urandom_range(0, 1) == 1) ? g : g ^ 3'd1);
        end

        idle(3);
        check("queue_empty7", exp_q.size(), 0);
        check("queue_empty1", exp1_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/round_scorer.md
ROUND_SCORER -- requirements
Module: round_scorer

Interface
REQ-001 SHALL have parameter ROUND_LEN, default 7: guesses per round; legal range 1..7.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000: idle cycles allowed per guess; used only with GUESS_TIMEOUT_EN.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port roundStart, input, 1 bit: one-cycle pulse that starts or restarts a round.
REQ-006 SHALL have port guess, input, 3 bits: symbol entered by the player.
REQ-007 SHALL have port guessValid, input, 1 bit: qualifies guess for one cycle.
REQ-008 SHALL have port expected, input, 3 bits: pattern symbol read from pattern memory at guessIdx, valid in the same cycle.
REQ-009 SHALL have port guessIdx, output, 3 bits: index of the current guess, 0..ROUND_LEN-1.
REQ-010 SHALL have port newScore, output, 3 bits: correct-guess count of the last completed round; this is the score_tracker newScore input.
REQ-011 SHALL have port scoreValid, output, 1 bit: one-cycle pulse marking an update of newScore.
REQ-012 SHALL have port busy, output, 1 bit: high while a round is in progress.

Function
REQ-013 SHALL implement the states IDLE, PLAY and DONE, with busy=1 only in PLAY.
REQ-014 SHALL, on roundStart in IDLE, enter PLAY on the next edge and clear guessIdx and the internal correct count to 0.
REQ-015 SHALL, on roundStart in PLAY, restart the round: counts cleared to 0, state stays PLAY, and any same-cycle guessValid ignored.
REQ-016 SHALL ignore roundStart in DONE.
REQ-017 SHALL ignore guessValid in IDLE and DONE.
REQ-018 SHALL, on guessValid in PLAY, compare guess with expected in that cycle, add 1 to the correct count on a match, and increment guessIdx.
REQ-019 SHALL, when the guess at guessIdx==ROUND_LEN-1 is accepted, enter DONE on the next edge and hold guessIdx at ROUND_LEN-1.
REQ-020 SHALL, on the edge that enters DONE, register newScore from the correct count including the final guess.
REQ-021 SHALL, in DONE (one cycle), pulse scoreValid high, then return to IDLE.
REQ-022 SHALL give a latency of exactly 1 cycle from the final guessValid to the scoreValid pulse.
REQ-023 SHALL hold newScore stable between scoreValid pulses.
REQ-024 SHALL keep newScore <= ROUND_LEN with no wrap, which a 3-bit count guarantees.

Reset
REQ-025 SHALL, when rst=1 at an edge, force state IDLE and guessIdx=0, newScore=0, scoreValid=0, busy=0, correct count=0, timer=0.
REQ-026 SHALL treat rst in PLAY as abandoning the round: no scoreValid pulse is produced.
REQ-027 SHALL let rst take priority over roundStart and guessValid in the same cycle.

Configuration
REQ-028 SHALL, with GUESS_TIMEOUT_EN defined, count consecutive PLAY cycles without guessValid.
REQ-029 SHALL, with GUESS_TIMEOUT_EN defined, treat the count reaching TIMEOUT_CYCLES as a wrong guess: guessIdx advances, no score, and the timer clears.
REQ-030 SHALL, with GUESS_TIMEOUT_EN defined, clear the timer on accepted guess, roundStart or leaving PLAY.
REQ-031 SHALL, with GUESS_TIMEOUT_EN defined, let guessValid win over a timeout expiring in the same cycle, so the guess is scored normally.
REQ-032 SHALL, with GUESS_TIMEOUT_EN undefined, omit the timer logic entirely and wait in PLAY indefinitely.

Structure
REQ-033 SHALL place the state encoding, SYMBOL_W=3 and SCORE_W=3 in the shared package memory_game_pkg.
REQ-034 SHALL implement the timeout counter as sub-module guess_timer, instantiated only under GUESS_TIMEOUT_EN.

Verification
REQ-035 SHALL cover: ROUND_LEN=7, roundStart, 7 guesses all matching expected -> scoreValid one cycle after the 7th guess, newScore=7, busy drops.
REQ-036 SHALL cover: guesses matching on indices 0, 2 and 5 only -> newScore=3; guessIdx steps 0..6 in order.
REQ-037 SHALL cover: roundStart after 4 guesses (3 correct), then 7 wrong guesses -> newScore=0, exactly one scoreValid.
REQ-038 SHALL cover: rst asserted after 5 guesses -> next cycle all outputs 0, state IDLE, no scoreValid; guessValid in IDLE ignored.
REQ-039 SHALL cover: GUESS_TIMEOUT_EN with TIMEOUT_CYCLES=10, no input for 10 cycles -> guessIdx 0->1, score unchanged; guessValid on the expiry cycle with a match -> count +1, single advance.
REQ-040 SHALL cover: ROUND_LEN=1, a single matching guess -> newScore=1 after 1 cycle; back-to-back rounds give a newScore update per round.
